// File: rtl/osc_entropy_collector.sv
// Samples the ring-oscillator noise bit, runs a repetition-count health test and packs bits into words.
// Define ENTROPY_VN_DEBIAS_EN to pair raw samples through a von Neumann debiaser before packing.
module osc_entropy_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int SAMPLE_DIV = 16,
    parameter int REP_LIMIT  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  noise_in,
    output logic [DATA_WIDTH-1:0] entropy_data,
    output logic                  entropy_valid,
    input  logic                  entropy_ack,
    output logic                  rep_alarm,
    input  logic                  alarm_clear
);
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BCNT_W = $clog2(DATA_WIDTH + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_WIDTH - 1);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [REP_W-1:0]      rep_q, rep_d;
    logic                  prev_q, prev_d;
    logic                  have_prev_q, have_prev_d;
    logic                  alarm_q, alarm_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
`ifdef ENTROPY_VN_DEBIAS_EN
    logic                  pair_full_q, pair_full_d;
    logic                  pair_first_q, pair_first_d;
`endif

    logic             strobe;
    logic             trigger;
    logic             take;
    logic             acc;
    logic             acc_bit;
    logic [REP_W-1:0] rep_calc;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bcnt_d      = bcnt_q;
        rep_d       = rep_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        alarm_d     = alarm_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        acc         = 1'b0;
        acc_bit     = 1'b0;
`ifdef ENTROPY_VN_DEBIAS_EN
        pair_full_d  = pair_full_q;
        pair_first_d = pair_first_q;
`endif

        strobe = enable && (div_q == DIV_LAST);
        if (have_prev_q && (sync2_q == prev_q))
            rep_calc = (rep_q == REP_MAX) ? REP_MAX : rep_q + 1'b1;
        else
            rep_calc = REP_W'(1);
        trigger = strobe && (rep_calc == REP_MAX);
        take    = strobe && !trigger && !alarm_q;

        if (!enable) begin
            div_d       = '0;
            bcnt_d      = '0;
            rep_d       = '0;
            have_prev_d = 1'b0;
`ifdef ENTROPY_VN_DEBIAS_EN
            pair_full_d = 1'b0;
`endif
        end else begin
            div_d = strobe ? '0 : div_q + 1'b1;
            if (strobe) begin
                rep_d       = rep_calc;
                prev_d      = sync2_q;
                have_prev_d = 1'b1;
            end
            if (trigger) begin
                alarm_d = 1'b1;
                bcnt_d  = '0;
`ifdef ENTROPY_VN_DEBIAS_EN
                pair_full_d = 1'b0;
`endif
            end
        end

`ifdef ENTROPY_VN_DEBIAS_EN
        // First sample of a pair is parked; the second decides: 10 -> 1, 01 -> 0, else nothing.
        if (take) begin
            if (!pair_full_q) begin
                pair_full_d  = 1'b1;
                pair_first_d = sync2_q;
            end else begin
                pair_full_d = 1'b0;
                acc         = (pair_first_q != sync2_q);
                acc_bit     = pair_first_q;
            end
        end
`else
        acc     = take;
        acc_bit = sync2_q;
`endif

        case (state_q)
            COLLECT: begin
                if (acc) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], acc_bit};
                    if (bcnt_q == BCNT_LAST) begin
                        data_d  = shift_d;
                        valid_d = 1'b1;
                        bcnt_d  = '0;
                        state_d = FULL;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (entropy_ack && valid_q) begin
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        // Clearing the alarm takes priority over a trigger in the same cycle.
        if (alarm_clear) begin
            alarm_d = 1'b0;
            rep_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= COLLECT;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            div_q       <= '0;
            bcnt_q      <= '0;
            rep_q       <= '0;
            prev_q      <= 1'b0;
            have_prev_q <= 1'b0;
            alarm_q     <= 1'b0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
`ifdef ENTROPY_VN_DEBIAS_EN
            pair_full_q  <= 1'b0;
            pair_first_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= noise_in;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            bcnt_q      <= bcnt_d;
            rep_q       <= rep_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            alarm_q     <= alarm_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
`ifdef ENTROPY_VN_DEBIAS_EN
            pair_full_q  <= pair_full_d;
            pair_first_q <= pair_first_d;
`endif
        end
    end

    assign entropy_data  = data_q;
    assign entropy_valid = valid_q;
    assign rep_alarm     = alarm_q;

endmodule

// File: tb/tb_osc_entropy_collector.sv
// Directed bench for osc_entropy_collector; expected words go to a queue checked by a negedge monitor.
module tb_osc_entropy_collector;
    localparam int DW  = 8;
    localparam int DIV = 4;
    localparam int RL  = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          noise_in;
    logic [DW-1:0] entropy_data;
    logic          entropy_valid;
    logic          entropy_ack;
    logic          rep_alarm;
    logic          alarm_clear;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;
    logic [DW-1:0] exp_q[$];

    osc_entropy_collector #(
        .DATA_WIDTH(DW),
        .SAMPLE_DIV(DIV),
        .REP_LIMIT (RL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .noise_in     (noise_in),
        .entropy_data (entropy_data),
        .entropy_valid(entropy_valid),
        .entropy_ack  (entropy_ack),
        .rep_alarm    (rep_alarm),
        .alarm_clear  (alarm_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a fresh word is popped against the scoreboard, a held word must not move.
    logic          prev_v = 1'b0;
    logic [DW-1:0] held   = '0;
    always @(negedge clk) begin
        if (entropy_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL word_unexpected: got %0h expected none", entropy_data);
            end else begin
                check("word", {24'b0, entropy_data}, {24'b0, exp_q.pop_front()});
            end
        end else if (entropy_valid && prev_v) begin
            check("word_hold", {24'b0, entropy_data}, {24'b0, held});
        end
        prev_v <= entropy_valid;
        held   <= entropy_data;
    end

    task automatic tick;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Leaves the bench 1 ns after the next strobe edge.
    task automatic to_strobe;
        do tick(); while (((cyc - base) % DIV) != 0);
    endtask

    task automatic send_bits(input logic [31:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            noise_in = pat[i];
            to_strobe();
        end
    endtask

    // Sends n raw samples, expecting word w exactly one cycle after the last strobe.
    task automatic send_word(input logic [31:0] pat, input int n, input logic [DW-1:0] w);
        exp_q.push_back(w);
        send_bits(pat >> 1, n - 1);
        noise_in = pat[0];
        repeat (DIV - 1) tick();
        check("valid_before_last", {31'b0, entropy_valid}, 32'd0);
        tick();
        check("valid_after_last", {31'b0, entropy_valid}, 32'd1);
        check("alarm_quiet", {31'b0, rep_alarm}, 32'd0);
    endtask

    task automatic do_ack;
        entropy_ack = 1'b1;
        tick();
        entropy_ack = 1'b0;
        check("valid_after_ack", {31'b0, entropy_valid}, 32'd0);
    endtask

    task automatic summary;
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        #200000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        noise_in    = 1'b0;
        entropy_ack = 1'b0;
        alarm_clear = 1'b0;
        tick();
        tick();
        check("rst_data", {24'b0, entropy_data}, 32'd0);
        check("rst_valid", {31'b0, entropy_valid}, 32'd0);
        check("rst_alarm", {31'b0, rep_alarm}, 32'd0);
        reset_n = 1'b1;
        tick();
        enable = 1'b1;
        base   = cyc;

`ifdef ENTROPY_VN_DEBIAS_EN
        // Pairs 10,00,01,11 x4 give bits 1,0 per group.
        send_word(32'h8787_8787, 32, 8'hAA);
        do_ack();
`else
        // Alternating samples
        send_word(32'hAA, 8, 8'hAA);
        do_ack();

        // Backpressure: word held for 25 strobes of toggling noise
        send_word(32'hAA, 8, 8'hAA);
        send_bits(32'h0155_5555, 25);
        check("bp_valid", {31'b0, entropy_valid}, 32'd1);
        check("bp_data", {24'b0, entropy_data}, 32'hAA);
        do_ack();
        send_word(32'h96, 8, 8'h96);
        do_ack();

        // Repetition alarm on a stuck-at-1 source
        noise_in = 1'b1;
        repeat (RL - 1) to_strobe();
        repeat (DIV - 1) tick();
        check("alarm_before_limit", {31'b0, rep_alarm}, 32'd0);
        tick();
        check("alarm_at_limit", {31'b0, rep_alarm}, 32'd1);
        to_strobe();
        check("alarm_sticky", {31'b0, rep_alarm}, 32'd1);
        check("alarm_no_word", {31'b0, entropy_valid}, 32'd0);
        alarm_clear = 1'b1;
        tick();
        alarm_clear = 1'b0;
        check("alarm_cleared", {31'b0, rep_alarm}, 32'd0);
        send_word(32'h66, 8, 8'h66);
        do_ack();

        // Partial word discarded by enable drop
        send_bits(32'h16, 5);
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        base   = cyc;
        send_word(32'hCC, 8, 8'hCC);

        // Alarm while a word is held, then async reset
        repeat (5) to_strobe();
        check("alarm_full_pre", {31'b0, rep_alarm}, 32'd0);
        to_strobe();
        check("alarm_full", {31'b0, rep_alarm}, 32'd1);
        check("valid_full", {31'b0, entropy_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst2_data", {24'b0, entropy_data}, 32'd0);
        check("rst2_valid", {31'b0, entropy_valid}, 32'd0);
        check("rst2_alarm", {31'b0, rep_alarm}, 32'd0);
        tick();
        reset_n = 1'b1;
        base    = cyc;
        send_word(32'h9A, 8, 8'h9A);
        do_ack();
`endif

        repeat (4) tick();
        check("queue_empty", exp_q.size(), 32'd0);
        summary();
        $finish;
    end

endmodule

// File: doc/osc_entropy_collector.md
Name: osc_entropy_collector

Overview:
Sits directly downstream of the adder-based ring oscillator cell. It samples that cell's single noise bit at a programmable rate and runs a repetition-count health test on the raw samples. Accepted bits are packed into DATA_WIDTH-bit words and handed to the consuming logic over a valid/ack handshake. This turns a free-running noise bit into checked, word-wide entropy for the downstream mixer/conditioner.

Parameters:
DATA_WIDTH, 32, bits per output word (>=2).
SAMPLE_DIV, 16, clk cycles between samples of the noise bit (>=1).
REP_LIMIT, 64, consecutive identical raw samples that raise the alarm (>=2).

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
enable  input  1  collection enable.
noise_in  input  1  raw noise bit from the oscillator cell.
entropy_data  output  DATA_WIDTH  completed entropy word.
entropy_valid  output  1  entropy_data holds an unconsumed word.
entropy_ack  input  1  consumer takes the word.
rep_alarm  output  1  sticky repetition-count health failure.
alarm_clear  input  1  clears rep_alarm.

Behaviour:
- Clocking and reset: one clock domain, clk. reset_n is asynchronous, active-low.
- Values while reset_n=0: entropy_data=0, entropy_valid=0, rep_alarm=0. All counters=0, FSM=COLLECT, synchroniser flops=0, pair state empty.
- Synchroniser: noise_in passes through a 2-flop synchroniser. Sampled value = synchroniser output.
- Divider: counter runs 0..SAMPLE_DIV-1 while enable=1. A strobe fires in the cycle the counter equals SAMPLE_DIV-1; the counter then wraps to 0.
- enable=0: divider, bit counter, pair state and repetition counter are forced to 0/empty. A held word (valid=1) is retained. rep_alarm is retained.
- Health test, evaluated on every strobe, including in FULL state:
  - sample == previous sample: rep count increments, saturating at REP_LIMIT.
  - otherwise: rep count = 1. The first sample after reset or enable also sets rep count = 1.
  - When rep count reaches REP_LIMIT, rep_alarm=1 in the next cycle. The triggering sample is not accepted, and the bit counter and pair state are cleared.
  - rep_alarm is sticky. alarm_clear=1 clears it next cycle and sets rep count to 0. If alarm_clear coincides with a trigger, clear wins.
  - While rep_alarm=1, no bits are accepted.
- FSM COLLECT:
  - Each accepted bit shifts into the shift register at bit 0; the register shifts left, so the first bit ends up in the MSB.
  - Bit counter width is clog2(DATA_WIDTH+1).
  - On the DATA_WIDTH-th accepted bit: entropy_data <= completed register and entropy_valid=1 in the next cycle, bit counter <= 0, FSM -> FULL.
- FSM FULL:
  - Accepted bits are discarded.
  - entropy_data is stable while valid=1.
  - entropy_ack=1 with valid=1: valid=0 next cycle, FSM -> COLLECT. entropy_data keeps its last value until overwritten.
  - entropy_ack while valid=0 is ignored.
- Latency: noise_in to sampled value is 2 cycles. Last accepted strobe to entropy_valid is 1 cycle.
- Reset mid-operation aborts everything to reset values immediately. No partial word survives.

Optional Feature:
ENTROPY_VN_DEBIAS_EN
- Defined: von Neumann debiasing. Strobe samples are paired (first, second).
  - Pair 10 accepts bit 1; pair 01 accepts bit 0; pairs 00 and 11 accept nothing.
  - Pair state clears on reset, on enable=0, and on alarm set.
  - The health test still uses every raw strobe sample.
- Undefined: every strobe sample is accepted directly (raw mode).

Test Plan:
(All scenarios use DATA_WIDTH=8, SAMPLE_DIV=4, REP_LIMIT=8.)
1. Raw mode, enable=1, noise_in sampled 1,0,1,0,1,0,1,0 on strobes 1..8 -> entropy_valid=1 one cycle after strobe 8, entropy_data=8'hAA, rep_alarm=0. Assert entropy_ack=1 for one cycle -> valid=0 next cycle.
2. Backpressure: word 8'hAA valid, entropy_ack held 0 for 100 cycles while noise keeps toggling -> entropy_data stays 8'hAA and valid stays 1. After ack, the next 8 strobes produce a new word.
3. Health: noise_in held 1 -> rep_alarm=1 one cycle after strobe 8, entropy_valid never asserts. Pulse alarm_clear=1 -> rep_alarm=0 next cycle. Next 8 samples 0,1,1,0,0,1,1,0 -> entropy_data=8'h66.
4. enable drop: after 5 accepted bits, enable=0 for 3 cycles then 1. Next 8 samples 1,1,0,0,1,1,0,0 -> entropy_data=8'hCC; the earlier 5 bits are absent.
5. ENTROPY_VN_DEBIAS_EN defined: raw pairs 10,00,01,11 repeated 4 times (32 strobes) -> entropy_data=8'hAA valid one cycle after strobe 32, rep_alarm=0.
6. reset_n=0 for 1 cycle while valid=1 and rep_alarm=1 -> entropy_data=0, entropy_valid=0 and rep_alarm=0 immediately. After release, the first word needs 8 fresh strobes.
